// File: rtl/can_tx_message_selector.sv
// ---------------------------------------------------------------------------
// can_tx_message_selector
// Picks the next TX message (HPB before FIFO), reads it as one 128-bit word,
// holds it for the bit stream processor, and handles done / error-retry /
// arbitration-loss outcomes. Single clock domain (i_sys_clk). All outputs
// are registered.
//
// Ports:
//   i_sys_clk, i_reset              clock, async active-high reset
//   i_enable                        gates new fetches in IDLE only
//   i_txhpb_full / i_txhpb_r_data   HPB status and read data
//   o_txhpb_r_en                    one-cycle HPB pop strobe
//   i_tx_fifo_empty / i_tx_fifo_r_data  FIFO status and read data
//   o_tx_fifo_r_en                  one-cycle FIFO pop strobe
//   o_tx_message / o_tx_valid       message presented to the BSP
//   i_tx_done / i_tx_arb_lost / i_tx_error  BSP outcome pulses
//   o_tx_src_hpb                    current message came from the HPB
//   o_txbsy                         message in flight
//   o_tx_ok / o_tx_drop             completion / give-up pulses
//   o_retry_cnt                     error retries of the current message
// ---------------------------------------------------------------------------
module can_tx_message_selector #(
  parameter int MAX_RETRIES = 0,
  parameter int RETRY_CNT_W = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_txhpb_full,
  input  logic [127:0]           i_txhpb_r_data,
  output logic                   o_txhpb_r_en,
  input  logic                   i_tx_fifo_empty,
  input  logic [127:0]           i_tx_fifo_r_data,
  output logic                   o_tx_fifo_r_en,
  output logic [127:0]           o_tx_message,
  output logic                   o_tx_valid,
  input  logic                   i_tx_done,
  input  logic                   i_tx_arb_lost,
  input  logic                   i_tx_error,
  output logic                   o_tx_src_hpb,
  output logic                   o_txbsy,
  output logic                   o_tx_ok,
  output logic                   o_tx_drop,
  output logic [RETRY_CNT_W-1:0] o_retry_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    RETRY   = 2'd3
  } state_t;

  localparam logic [RETRY_CNT_W:0] MAX_R = (RETRY_CNT_W + 1)'(MAX_RETRIES);

  state_t state;
  // Read data is valid the cycle after the strobe, so FETCH spends its first
  // cycle waiting while the strobe is visible and captures on the second.
  logic   fetch_wait;

  logic [RETRY_CNT_W:0] retry_next;
  logic                 err_limit;
  logic                 cnt_sat;

  // One extra bit so the compare against MAX_RETRIES cannot wrap.
  assign retry_next = {1'b0, o_retry_cnt} + {{RETRY_CNT_W{1'b0}}, 1'b1};
  assign err_limit  = (MAX_RETRIES != 32'sd0) && (retry_next == MAX_R);
  assign cnt_sat    = &o_retry_cnt;

  // Selector FSM with all outputs registered.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      fetch_wait     <= 1'b0;
      o_txhpb_r_en   <= 1'b0;
      o_tx_fifo_r_en <= 1'b0;
      o_tx_message   <= 128'h0;
      o_tx_valid     <= 1'b0;
      o_tx_src_hpb   <= 1'b0;
      o_txbsy        <= 1'b0;
      o_tx_ok        <= 1'b0;
      o_tx_drop      <= 1'b0;
      o_retry_cnt    <= {RETRY_CNT_W{1'b0}};
    end else begin
      // Strobes and status pulses last a single cycle.
      o_txhpb_r_en   <= 1'b0;
      o_tx_fifo_r_en <= 1'b0;
      o_tx_ok        <= 1'b0;
      o_tx_drop      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable && i_txhpb_full) begin
            o_txhpb_r_en <= 1'b1;
            o_tx_src_hpb <= 1'b1;
            o_txbsy      <= 1'b1;
            fetch_wait   <= 1'b1;
            state        <= FETCH;
          end else if (i_enable && !i_tx_fifo_empty) begin
            o_tx_fifo_r_en <= 1'b1;
            o_tx_src_hpb   <= 1'b0;
            o_txbsy        <= 1'b1;
            fetch_wait     <= 1'b1;
            state          <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else begin
            o_tx_message <= o_tx_src_hpb ? i_txhpb_r_data : i_tx_fifo_r_data;
            o_retry_cnt  <= {RETRY_CNT_W{1'b0}};
            o_tx_valid   <= 1'b1;
            state        <= PRESENT;
          end
        end
        PRESENT: begin
          // Coinciding events resolve as done > error > arbitration loss.
          if (i_tx_done) begin
            o_tx_valid <= 1'b0;
            o_tx_ok    <= 1'b1;
            o_txbsy    <= 1'b0;
            state      <= IDLE;
          end else if (i_tx_error) begin
            o_tx_valid <= 1'b0;
            if (err_limit) begin
              o_tx_drop <= 1'b1;
              o_txbsy   <= 1'b0;
              state     <= IDLE;
            end else begin
              if (!cnt_sat) begin
                o_retry_cnt <= retry_next[RETRY_CNT_W-1:0];
              end else begin
                o_retry_cnt <= o_retry_cnt;
              end
              state <= RETRY;
            end
          end else if (i_tx_arb_lost) begin
            o_tx_valid <= 1'b0;
            state      <= RETRY;
          end else begin
            state <= PRESENT;
          end
        end
        RETRY: begin
          // Same message goes back out; no re-read and no preemption.
          o_tx_valid <= 1'b1;
          state      <= PRESENT;
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_txbsy    <= 1'b0;
          fetch_wait <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_message_selector.sv
// ---------------------------------------------------------------------------
// Testbench for can_tx_message_selector (MAX_RETRIES = 3).
// Behavioural HPB/FIFO model, expected-message scoreboard filled by the
// stimulus and drained whenever a new message is first presented.
// ---------------------------------------------------------------------------
module tb_can_tx_message_selector;

  localparam int RW = 4;

  logic           sys_clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           txhpb_full;
  logic [127:0]   txhpb_r_data;
  logic           txhpb_r_en;
  logic           tx_fifo_empty;
  logic [127:0]   tx_fifo_r_data;
  logic           tx_fifo_r_en;
  logic [127:0]   tx_message;
  logic           tx_valid;
  logic           tx_done;
  logic           tx_arb_lost;
  logic           tx_error;
  logic           tx_src_hpb;
  logic           txbsy;
  logic           tx_ok;
  logic           tx_drop;
  logic [RW-1:0]  retry_cnt;

  typedef struct packed {
    logic         src;
    logic [127:0] msg;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         cur_exp;
  logic [127:0] fifo_q[$];
  logic [127:0] hpb_slot;
  logic         need_new;
  logic         prev_valid;
  int           n_checks;
  int           n_err;
  int           n_hpb_rd;
  int           n_fifo_rd;
  int           n_ok;
  int           n_drop;
  int           snap;

  can_tx_message_selector #(.MAX_RETRIES(3), .RETRY_CNT_W(RW)) dut (
    .i_sys_clk        (sys_clk),
    .i_reset          (reset),
    .i_enable         (enable),
    .i_txhpb_full     (txhpb_full),
    .i_txhpb_r_data   (txhpb_r_data),
    .o_txhpb_r_en     (txhpb_r_en),
    .i_tx_fifo_empty  (tx_fifo_empty),
    .i_tx_fifo_r_data (tx_fifo_r_data),
    .o_tx_fifo_r_en   (tx_fifo_r_en),
    .o_tx_message     (tx_message),
    .o_tx_valid       (tx_valid),
    .i_tx_done        (tx_done),
    .i_tx_arb_lost    (tx_arb_lost),
    .i_tx_error       (tx_error),
    .o_tx_src_hpb     (tx_src_hpb),
    .o_txbsy          (txbsy),
    .o_tx_ok          (tx_ok),
    .o_tx_drop        (tx_drop),
    .o_retry_cnt      (retry_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_fifo(input logic [127:0] m, input logic expect_it);
    exp_t e;
    fifo_q.push_back(m);
    tx_fifo_empty = 1'b0;
    if (expect_it) begin
      e.src = 1'b0;
      e.msg = m;
      exp_q.push_back(e);
    end
  endtask

  // One clock: storage model reacts to strobes, then outputs are monitored.
  task automatic tick();
    logic hr;
    logic fr;
    hr = txhpb_r_en;
    fr = tx_fifo_r_en;
    @(posedge sys_clk);
    #1;
    if (hr) begin
      txhpb_r_data = hpb_slot;
      txhpb_full   = 1'b0;
    end
    if (fr && fifo_q.size() > 0) tx_fifo_r_data = fifo_q.pop_front();
    tx_fifo_empty = (fifo_q.size() == 0);
    chk("strobe_excl", {127'd0, txhpb_r_en & tx_fifo_r_en}, 128'd0);
    n_hpb_rd  += int'(txhpb_r_en);
    n_fifo_rd += int'(tx_fifo_r_en);
    n_ok      += int'(tx_ok);
    n_drop    += int'(tx_drop);
    if (tx_valid && !prev_valid) begin
      if (need_new) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 128'd1, 128'd0);
        end else begin
          cur_exp  = exp_q.pop_front();
          need_new = 1'b0;
        end
      end
      chk("tx_message", tx_message, cur_exp.msg);
      chk("tx_src_hpb", {127'd0, tx_src_hpb}, {127'd0, cur_exp.src});
    end
    if (tx_ok || tx_drop) need_new = 1'b1;
    prev_valid = tx_valid;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!tx_valid && k < 20) begin
      tick();
      k++;
    end
    chk(tag, {127'd0, tx_valid}, 128'd1);
  endtask

  task automatic wait_strobe(input string tag);
    int k;
    k = 0;
    while (!(txhpb_r_en || tx_fifo_r_en) && k < 20) begin
      tick();
      k++;
    end
    chk(tag, {127'd0, txhpb_r_en | tx_fifo_r_en}, 128'd1);
  endtask

  task automatic pulse(input logic d, input logic e, input logic a);
    tx_done     = d;
    tx_error    = e;
    tx_arb_lost = a;
    tick();
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    tx_arb_lost = 1'b0;
  endtask

  initial begin
    exp_t e;
    n_checks = 0; n_err = 0; n_hpb_rd = 0; n_fifo_rd = 0; n_ok = 0; n_drop = 0;
    need_new = 1'b1; prev_valid = 1'b0; cur_exp = '0; hpb_slot = 128'h0;
    reset = 1'b1; enable = 1'b0; txhpb_full = 1'b0; txhpb_r_data = 128'h0;
    tx_fifo_empty = 1'b1; tx_fifo_r_data = 128'h0;
    tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;

    // Reset state.
    tick(); tick();
    chk("rst_ctrl", {118'd0, txhpb_r_en, tx_fifo_r_en, tx_valid, tx_src_hpb, txbsy,
                     tx_ok, tx_drop, retry_cnt}, 128'd0);
    chk("rst_msg", tx_message, 128'h0);
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // FIFO single message: valid two cycles after the strobe.
    push_fifo({32{4'hA, 4'h5}}, 1'b1);
    wait_strobe("fifo_strobe_to");
    chk("fifo_strobe_src", {126'd0, txhpb_r_en, tx_fifo_r_en}, 128'd1);
    tick();
    chk("valid_lat1", {127'd0, tx_valid}, 128'd0);
    tick();
    chk("valid_lat2", {127'd0, tx_valid}, 128'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("fifo_ok", {126'd0, tx_ok, txbsy}, 128'd2);
    chk("fifo_rd_once", 128'(n_fifo_rd), 128'd1);

    // HPB and FIFO ready together: HPB wins, FIFO follows.
    hpb_slot   = {4{32'h1234_5678}};
    txhpb_full = 1'b1;
    e.src = 1'b1; e.msg = hpb_slot; exp_q.push_back(e);
    push_fifo({4{32'hCAFE_F00D}}, 1'b1);
    wait_strobe("prio_strobe_to");
    chk("prio_strobe_src", {126'd0, txhpb_r_en, tx_fifo_r_en}, 128'd2);
    wait_valid("prio_valid_to");
    pulse(1'b1, 1'b0, 1'b0);
    chk("prio_ok1", {127'd0, tx_ok}, 128'd1);
    wait_valid("prio2_valid_to");
    pulse(1'b1, 1'b0, 1'b0);
    chk("prio_ok2", {127'd0, tx_ok}, 128'd1);
    chk("prio_rd_counts", 128'({n_hpb_rd[15:0], n_fifo_rd[15:0]}), 128'({16'd1, 16'd2}));

    // Arbitration loss three times, then success.
    push_fifo({8{16'hC3C3}}, 1'b1);
    wait_valid("arb_valid_to");
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      chk("arb_gap", {127'd0, tx_valid}, 128'd0);
      chk("arb_msg_hold", tx_message, cur_exp.msg);
      chk("arb_retry_cnt", 128'(retry_cnt), 128'd0);
      tick();
      chk("arb_back", {127'd0, tx_valid}, 128'd1);
    end
    pulse(1'b1, 1'b0, 1'b0);
    chk("arb_ok", {127'd0, tx_ok}, 128'd1);

    // Error limit: third error drops the message.
    snap = n_ok;
    push_fifo({16{8'hE7}}, 1'b1);
    wait_valid("err_valid_to");
    pulse(1'b0, 1'b1, 1'b0);
    chk("err1", {123'd0, tx_valid, retry_cnt}, 128'd1);
    tick();
    pulse(1'b0, 1'b1, 1'b0);
    chk("err2", {123'd0, tx_valid, retry_cnt}, 128'd2);
    tick();
    pulse(1'b0, 1'b1, 1'b0);
    chk("err3_drop", {124'd0, tx_drop, tx_valid, txbsy, tx_ok}, 128'd8);
    tick();
    chk("err_no_ok", 128'(n_ok - snap), 128'd0);
    chk("err_drop_cnt", 128'(n_drop), 128'd1);

    // Done and error together: done wins.
    push_fifo({4{32'h0BAD_BEEF}}, 1'b1);
    wait_valid("sim_valid_to");
    pulse(1'b1, 1'b1, 1'b0);
    chk("sim_ok", {124'd0, tx_ok, tx_drop, tx_valid, txbsy}, 128'd8);
    chk("sim_retry_cnt", 128'(retry_cnt), 128'd0);

    // Async reset in PRESENT, then enable gating.
    push_fifo({4{32'h5EED_0001}}, 1'b1);
    wait_valid("rst_valid_to");
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ctrl", {118'd0, txhpb_r_en, tx_fifo_r_en, tx_valid, tx_src_hpb, txbsy,
                           tx_ok, tx_drop, retry_cnt}, 128'd0);
    chk("async_rst_msg", tx_message, 128'h0);
    need_new = 1'b1;
    snap = n_hpb_rd + n_fifo_rd;
    push_fifo({4{32'h7777_1111}}, 1'b0);
    tick(); tick(); tick();
    chk("rst_no_strobe", 128'(n_hpb_rd + n_fifo_rd - snap), 128'd0);
    enable = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("dis_no_strobe", 128'(n_hpb_rd + n_fifo_rd - snap), 128'd0);
    chk("dis_idle", {126'd0, txbsy, tx_valid}, 128'd0);
    e.src = 1'b0; e.msg = {4{32'h7777_1111}}; exp_q.push_back(e);
    enable = 1'b1;
    wait_valid("en_valid_to");
    pulse(1'b1, 1'b0, 1'b0);
    chk("en_ok", {127'd0, tx_ok}, 128'd1);
    tick();
    chk("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/can_tx_message_selector.md
Name: can_tx_message_selector

Overview:
- TX-path counterpart of the RX acceptance filter. It selects the next message from the TX high-priority buffer (HPB) or the TX FIFO and reads it as a 128-bit word.
- It holds the message and presents it to the bit stream processor (BSP) for transmission.
- It handles completion, arbitration loss and error retry, and reports status back to the configuration register block.
- Sits between the TX FIFO/HPB storage and the BSP, all in the i_sys_clk domain. BSP handshake inputs arrive already synchronized to i_sys_clk.

Parameters:
- MAX_RETRIES, 0, number of error-terminated attempts before the message is dropped; 0 = retry forever.
- RETRY_CNT_W, 4, width of the retry counter; must satisfy 2^RETRY_CNT_W > MAX_RETRIES.

Ports:
- i_sys_clk  in  1  system clock, single clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  from config register; high = normal mode; gates new fetches only.
- i_txhpb_full  in  1  HPB holds a message.
- i_txhpb_r_data  in  128  HPB read data, valid the cycle after o_txhpb_r_en.
- o_txhpb_r_en  out  1  one-cycle HPB read/pop strobe.
- i_tx_fifo_empty  in  1  TX FIFO empty flag.
- i_tx_fifo_r_data  in  128  FIFO read data, valid the cycle after o_tx_fifo_r_en.
- o_tx_fifo_r_en  out  1  one-cycle FIFO read/pop strobe.
- o_tx_message  out  128  message to BSP; [127:96] = ID word, same layout as RX.
- o_tx_valid  out  1  message presented to BSP for transmission.
- i_tx_done  in  1  one-cycle pulse: frame transmitted and acknowledged.
- i_tx_arb_lost  in  1  one-cycle pulse: arbitration lost.
- i_tx_error  in  1  one-cycle pulse: frame aborted by bus error.
- o_tx_src_hpb  out  1  current message came from HPB.
- o_txbsy  out  1  a message is in flight (any state other than IDLE).
- o_tx_ok  out  1  one-cycle pulse on successful transmission.
- o_tx_drop  out  1  one-cycle pulse when a message is dropped after MAX_RETRIES errors.
- o_retry_cnt  out  RETRY_CNT_W  error retries of the current message.

Behaviour:
- Reset (asynchronous):
  - All outputs are 0, including o_tx_message = 128'h0.
  - State = IDLE and the retry counter is cleared.
  - Reset mid-transmission abandons the message without a pulse on o_tx_ok or o_tx_drop.
- States: IDLE, FETCH, PRESENT, RETRY.
- IDLE:
  - If i_enable & i_txhpb_full: pulse o_txhpb_r_en, set src_hpb=1, go to FETCH.
  - Else if i_enable & !i_tx_fifo_empty: pulse o_tx_fifo_r_en, set src_hpb=0, go to FETCH.
  - HPB has strict priority when both sources are available in the same cycle.
  - Exactly one read strobe per message; never both strobes in the same cycle.
- FETCH:
  - Register the selected r_data into o_tx_message and clear the retry counter.
  - Go to PRESENT. o_tx_valid rises the cycle after FETCH, i.e. 2 cycles after the IDLE decision.
- PRESENT:
  - o_tx_valid=1 and o_tx_message is held stable.
  - Event priority when pulses coincide: i_tx_done > i_tx_error > i_tx_arb_lost.
  - On i_tx_done: pulse o_tx_ok next cycle, drop o_tx_valid, go to IDLE.
  - On i_tx_error with MAX_RETRIES!=0 and retry_cnt+1==MAX_RETRIES: pulse o_tx_drop, drop o_tx_valid, go to IDLE.
  - On any other i_tx_error: increment retry_cnt (saturating at all-ones), go to RETRY.
  - On i_tx_arb_lost: go to RETRY with no counter change (arbitration loss is not an error).
- RETRY:
  - o_tx_valid=0 for exactly one cycle, then back to PRESENT with the same message.
  - The message is not re-read and there is no preemption: a newly arriving HPB message waits until the current one completes.
- Handshake pulses received in IDLE, FETCH or RETRY are ignored.
- i_enable deasserted during FETCH, PRESENT or RETRY does not abort the message; it only blocks the next fetch in IDLE.
- Back-to-back throughput: after an o_tx_ok cycle, IDLE may issue the next read strobe in that same cycle.
- o_tx_src_hpb and o_retry_cnt stay valid from FETCH until the next FETCH.

Test Plan:
- FIFO single message: FIFO holds 0xA5..A5 with i_enable=1.
  - Required: o_tx_fifo_r_en pulses once; o_tx_valid rises 2 cycles later with o_tx_message=0xA5..A5, o_tx_src_hpb=0.
  - Then i_tx_done -> o_tx_ok pulse, o_txbsy=0.
- Priority: i_txhpb_full=1 and FIFO non-empty in the same cycle.
  - Required: o_txhpb_r_en only, o_tx_src_hpb=1. The FIFO message is sent after the first o_tx_ok.
- Arbitration loss: 3 i_tx_arb_lost pulses, then i_tx_done.
  - Required: 3 one-cycle o_tx_valid gaps with unchanged o_tx_message, o_retry_cnt=0, then o_tx_ok.
- Error limit with MAX_RETRIES=3: 3 i_tx_error pulses.
  - Required: o_retry_cnt goes 1, then 2; the third error gives an o_tx_drop pulse, o_tx_valid=0, state IDLE, no o_tx_ok.
- Simultaneous events: i_tx_done and i_tx_error in the same cycle -> o_tx_ok, no retry.
- Reset and enable: async i_reset asserted in PRESENT.
  - Required: all outputs 0 immediately and no read strobes afterwards.
  - With i_enable=0 and the FIFO non-empty, no read strobe is issued.
